// File: rtl/transient_network_ctrl.sv
// transient_network_ctrl: FSM-driven power-transient generator.
// N_BANKS banks of BANK_SIZE toggle flops are clock-enabled in bursts (on_cycles high,
// off_cycles gap, n_pulses bursts per trigger) so that a neighbouring TDC sensor can
// observe the resulting supply droop. The yes[] output exposes the last flop of each
// bank so that synthesis keeps every bank alive.
// Optional feature: define TNET_RAMP_EN for a soft ramp, where bank b is enabled b
// cycles after each burst starts. Default build: TNET_RAMP_EN undefined, and all
// selected banks switch on in the same cycle.
module transient_network_ctrl #(
  parameter int N_BANKS   = 8,
  parameter int BANK_SIZE = 100,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               trigger,
  input  logic               abort,
  input  logic [N_BANKS-1:0] bank_mask,
  input  logic [CNT_W-1:0]   on_cycles,
  input  logic [CNT_W-1:0]   off_cycles,
  input  logic [CNT_W-1:0]   n_pulses,
  output logic               busy,
  output logic               done,
  output logic               burst_active,
  output logic [CNT_W-1:0]   pulse_cnt,
  output logic [N_BANKS-1:0] yes
);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_BURST, S_GAP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0]   on_q, on_d, off_q, off_d, n_q, n_d;
  logic [N_BANKS-1:0] mask_q, mask_d;
  logic               busy_q, busy_d, done_q, done_d, active_q, active_d;
  logic               sync1_q, sync2_q, prev_q, trig_rise_s;
  logic [CNT_W-1:0]   pulse_next_s;
  logic [N_BANKS-1:0] ce_s;
  logic [BANK_SIZE-1:0] bank_q [N_BANKS];
  logic [BANK_SIZE-1:0] bank_d [N_BANKS];

  // Trigger synchroniser; resets to 1 so a trigger held high through reset is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= trigger;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign trig_rise_s  = sync2_q & ~prev_q;
  assign pulse_next_s = pulse_cnt_q + CNT_W'(1);

  // Next-state, counter and registered-output computation for the burst sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    on_d        = on_q;
    off_d       = off_q;
    n_d         = n_q;
    mask_d      = mask_q;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            on_d        = on_cycles;
            off_d       = off_cycles;
            n_d         = n_pulses;
            mask_d      = bank_mask;
            pulse_cnt_d = '0;
            state_d     = S_ARMED;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ARMED: begin
          if (trig_rise_s) begin
            cnt_d = '0;
            if ((on_q == '0) || (n_q == '0)) state_d = S_DONE;
            else                             state_d = S_BURST;
          end else begin
            state_d = S_ARMED;
          end
        end
        S_BURST: begin
          if (cnt_q == (on_q - CNT_W'(1))) begin
            cnt_d       = '0;
            pulse_cnt_d = pulse_next_s;
            if (pulse_next_s == n_q)   state_d = S_DONE;
            else if (off_q == '0)      state_d = S_BURST;
            else                       state_d = S_GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == (off_q - CNT_W'(1))) begin
            cnt_d   = '0;
            state_d = S_BURST;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d   = (state_d == S_ARMED) || (state_d == S_BURST) || (state_d == S_GAP);
    active_d = (state_d == S_BURST);
    done_d   = (state_d == S_DONE);
  end

  // Sequencer state, latched configuration and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pulse_cnt_q <= '0;
      on_q        <= '0;
      off_q       <= '0;
      n_q         <= '0;
      mask_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse_cnt_q <= pulse_cnt_d;
      on_q        <= on_d;
      off_q       <= off_d;
      n_q         <= n_d;
      mask_q      <= mask_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      active_q    <= active_d;
    end
  end

`ifdef TNET_RAMP_EN
  logic [N_BANKS-2:0] ramp_q, ramp_d;
  logic               first_s;

  // cnt_q is zero only on the first cycle of each burst, which restarts the ramp.
  assign first_s = (state_q == S_BURST) && (cnt_q == '0);

  // Ramp chain: stage k enables bank k+1 one cycle after bank k.
  always_comb begin
    ramp_d    = '0;
    ramp_d[0] = active_q;
    for (int k = 1; k < N_BANKS - 1; k++) begin
      ramp_d[k] = ramp_q[k-1] & active_q & ~first_s;
    end
  end

  // Ramp stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ramp_q <= '0;
    else        ramp_q <= ramp_d;
  end

  // Bank enables: bank 0 immediately, later banks from the ramp chain, all cut when the burst ends.
  always_comb begin
    ce_s    = '0;
    ce_s[0] = active_q & mask_q[0];
    for (int b = 1; b < N_BANKS; b++) begin
      ce_s[b] = ramp_q[b-1] & active_q & ~first_s & mask_q[b];
    end
  end
`else
  // Every selected bank switches in the same cycle for maximum di/dt.
  always_comb begin
    ce_s = {N_BANKS{active_q}} & mask_q;
  end
`endif

  // Toggle-bank next value: every flop in an enabled bank inverts.
  always_comb begin
    for (int b = 0; b < N_BANKS; b++) begin
      bank_d[b] = ce_s[b] ? ~bank_q[b] : bank_q[b];
    end
  end

  // Toggle-bank registers; async reset clears them even mid-burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < N_BANKS; b++) bank_q[b] <= '0;
    end else begin
      for (int b = 0; b < N_BANKS; b++) bank_q[b] <= bank_d[b];
    end
  end

  // Expose the last flop of each bank.
  always_comb begin
    for (int b = 0; b < N_BANKS; b++) yes[b] = bank_q[b][BANK_SIZE-1];
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign burst_active = active_q;
  assign pulse_cnt    = pulse_cnt_q;

endmodule

// File: tb/tb_transient_network_ctrl.sv
// Directed testbench for transient_network_ctrl (default build or TNET_RAMP_EN).
module tb_transient_network_ctrl;

  logic        clk, rst_n, start, trigger, abort;
  logic [7:0]  bank_mask;
  logic [15:0] on_cycles, off_cycles, n_pulses;
  logic        busy, done, burst_active;
  logic [15:0] pulse_cnt;
  logic [7:0]  yes;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] act_tr, done_tr, busy_tr;
  logic [7:0]  exp_yes;

  transient_network_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trigger(trigger), .abort(abort),
    .bank_mask(bank_mask), .on_cycles(on_cycles), .off_cycles(off_cycles),
    .n_pulses(n_pulses), .busy(busy), .done(done), .burst_active(burst_active),
    .pulse_cnt(pulse_cnt), .yes(yes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected burst_active trace; index k = sample after the k-th clock edge since trigger rose.
  function automatic logic [63:0] exp_act(input int on, input int off, input int n);
    logic [63:0] r;
    int s;
    r = '0;
    s = 3;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < on; c++) if (s + c < 64) r[s+c] = 1'b1;
      s = s + on + off;
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_done(input int on, input int off, input int n);
    logic [63:0] one;
    one = 64'd1;
    if (on == 0 || n == 0) return one << 3;
    return one << (3 + n * on + (n - 1) * off);
  endfunction

  // Toggles of bank b in one burst of length on.
  function automatic int bank_toggles(input int on, input int b);
`ifdef TNET_RAMP_EN
    return (on > b) ? on - b : 0;
`else
    return on;
`endif
  endfunction

  function automatic logic [7:0] yes_after(input logic [7:0] y, input logic [7:0] m,
                                           input int on, input int n);
    logic [7:0] r;
    r = y;
    for (int b = 0; b < 8; b++)
      if (m[b] && (((bank_toggles(on, b) * n) % 2) == 1)) r[b] = ~r[b];
    return r;
  endfunction

  // Issue a one-cycle start with the given configuration; returns at a negedge.
  task automatic do_start(input int on, input int off, input int n, input logic [7:0] m);
    @(negedge clk);
    on_cycles  = 16'(on);
    off_cycles = 16'(off);
    n_pulses   = 16'(n);
    bank_mask  = m;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Raise trigger at the current negedge and record outputs for ncyc cycles.
  task automatic fire_and_capture(input int ncyc, input int abort_at);
    act_tr  = '0;
    done_tr = '0;
    busy_tr = '0;
    trigger = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      @(negedge clk);
      act_tr[k]  = burst_active;
      done_tr[k] = done;
      busy_tr[k] = busy;
      if (k == 5) trigger = 1'b0;
      abort = (k == abort_at) ? 1'b1 : 1'b0;
    end
    abort = 1'b0;
  endtask

  task automatic test_reset;
    logic any_act;
    rst_n = 1'b0; trigger = 1'b1; start = 1'b0; abort = 1'b0;
    bank_mask = 8'h00; on_cycles = 16'd0; off_cycles = 16'd0; n_pulses = 16'd0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (burst_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %b want 0", burst_active); end
    n_checks++; if (pulse_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_pulse_cnt got %0d want 0", pulse_cnt); end
    n_checks++; if (yes !== 8'h00) begin n_fail++; $display("FAIL reset_yes got %h want 00", yes); end
    rst_n = 1'b1;
    exp_yes = 8'h00;
    // Trigger held high across reset release must not count as an edge.
    do_start(1, 0, 1, 8'h00);
    any_act = 1'b0;
    repeat (6) begin @(negedge clk); any_act = any_act | burst_active; end
    n_checks++; if (any_act !== 1'b0) begin n_fail++; $display("FAIL held_trigger_active got %b want 0", any_act); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL held_trigger_busy got %b want 1", busy); end
    trigger = 1'b0;
    repeat (3) @(negedge clk);
    fire_and_capture(20, 0);
    n_checks++; if (act_tr !== exp_act(1, 0, 1)) begin n_fail++; $display("FAIL rearm_act got %h want %h", act_tr, exp_act(1, 0, 1)); end
    n_checks++; if (done_tr !== exp_done(1, 0, 1)) begin n_fail++; $display("FAIL rearm_done got %h want %h", done_tr, exp_done(1, 0, 1)); end
    n_checks++; if (yes !== exp_yes) begin n_fail++; $display("FAIL mask0_yes got %h want %h", yes, exp_yes); end
  endtask

  task automatic test_basic_train;
    do_start(5, 3, 2, 8'hFF);
    fire_and_capture(30, 0);
    exp_yes = yes_after(exp_yes, 8'hFF, 5, 2);
    n_checks++; if (act_tr !== exp_act(5, 3, 2)) begin n_fail++; $display("FAIL basic_act got %h want %h", act_tr, exp_act(5, 3, 2)); end
    n_checks++; if (done_tr !== exp_done(5, 3, 2)) begin n_fail++; $display("FAIL basic_done got %h want %h", done_tr, exp_done(5, 3, 2)); end
    n_checks++; if (pulse_cnt !== 16'd2) begin n_fail++; $display("FAIL basic_pulse_cnt got %0d want 2", pulse_cnt); end
    n_checks++; if (yes !== exp_yes) begin n_fail++; $display("FAIL basic_yes got %h want %h", yes, exp_yes); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got %b want 0", busy); end
  endtask

  task automatic test_bank_mask;
    do_start(3, 2, 1, 8'h05);
    fire_and_capture(20, 0);
    exp_yes = yes_after(exp_yes, 8'h05, 3, 1);
    n_checks++; if (yes !== 8'h05) begin n_fail++; $display("FAIL mask_yes got %h want 05", yes); end
    n_checks++; if (done_tr !== exp_done(3, 2, 1)) begin n_fail++; $display("FAIL mask_done got %h want %h", done_tr, exp_done(3, 2, 1)); end
    n_checks++; if (pulse_cnt !== 16'd1) begin n_fail++; $display("FAIL mask_pulse_cnt got %0d want 1", pulse_cnt); end
  endtask

  task automatic test_back_to_back;
    do_start(4, 0, 3, 8'hFF);
    fire_and_capture(30, 0);
    exp_yes = yes_after(exp_yes, 8'hFF, 4, 3);
    n_checks++; if (act_tr !== 64'h0000_0000_0000_7FF8) begin n_fail++; $display("FAIL b2b_act got %h want 7ff8", act_tr); end
    n_checks++; if (done_tr !== 64'h0000_0000_0000_8000) begin n_fail++; $display("FAIL b2b_done got %h want 8000", done_tr); end
    n_checks++; if (pulse_cnt !== 16'd3) begin n_fail++; $display("FAIL b2b_pulse_cnt got %0d want 3", pulse_cnt); end
    n_checks++; if (yes !== exp_yes) begin n_fail++; $display("FAIL b2b_yes got %h want %h", yes, exp_yes); end
  endtask

  task automatic test_abort;
    // abort and start together in IDLE: abort wins.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_beats_start busy got %b want 0", busy); end
    do_start(10, 2, 4, 8'h0F);
    fire_and_capture(20, 4);
    exp_yes = yes_after(exp_yes, 8'h0F, 2, 1);
    n_checks++; if (act_tr !== 64'h18) begin n_fail++; $display("FAIL abort_act got %h want 18", act_tr); end
    n_checks++; if (busy_tr !== 64'h1E) begin n_fail++; $display("FAIL abort_busy got %h want 1e", busy_tr); end
    n_checks++; if (done_tr !== 64'h0) begin n_fail++; $display("FAIL abort_done got %h want 0", done_tr); end
    n_checks++; if (pulse_cnt !== 16'd0) begin n_fail++; $display("FAIL abort_pulse_cnt got %0d want 0", pulse_cnt); end
    n_checks++; if (yes !== exp_yes) begin n_fail++; $display("FAIL abort_yes got %h want %h", yes, exp_yes); end
  endtask

  task automatic test_zero_pulses;
    // Trigger edge while IDLE does nothing.
    fire_and_capture(10, 0);
    n_checks++; if ((act_tr | done_tr | busy_tr) !== 64'h0) begin n_fail++; $display("FAIL idle_trigger got %h want 0", act_tr | done_tr | busy_tr); end
    do_start(5, 1, 0, 8'hFF);
    do_start(3, 1, 2, 8'hFF);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy got %b want 1", busy); end
    fire_and_capture(20, 0);
    n_checks++; if (act_tr !== 64'h0) begin n_fail++; $display("FAIL zero_act got %h want 0", act_tr); end
    n_checks++; if (done_tr !== 64'h8) begin n_fail++; $display("FAIL zero_done got %h want 8", done_tr); end
    n_checks++; if (pulse_cnt !== 16'd0) begin n_fail++; $display("FAIL zero_pulse_cnt got %0d want 0", pulse_cnt); end
    n_checks++; if (yes !== exp_yes) begin n_fail++; $display("FAIL zero_yes got %h want %h", yes, exp_yes); end
  endtask

  task automatic test_async_reset;
    logic [7:0] mid_yes;
    do_start(10, 1, 1, 8'hFF);
    trigger = 1'b1;
    repeat (6) begin @(posedge clk); @(negedge clk); end
    mid_yes = yes_after(exp_yes, 8'hFF, 3, 1);
    n_checks++; if (yes !== mid_yes) begin n_fail++; $display("FAIL midburst_yes got %h want %h", yes, mid_yes); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (yes !== 8'h00) begin n_fail++; $display("FAIL async_rst_yes got %h want 00", yes); end
    n_checks++; if ({busy, burst_active, done} !== 3'b000) begin n_fail++; $display("FAIL async_rst_status got %b want 000", {busy, burst_active, done}); end
    @(negedge clk);
    rst_n = 1'b1;
    trigger = 1'b0;
    exp_yes = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_all_banks;
    int on;
    logic [7:0] want;
`ifdef TNET_RAMP_EN
    on = 4; want = 8'h0A;
`else
    on = 5; want = 8'hFF;
`endif
    do_start(on, 1, 1, 8'hFF);
    fire_and_capture(20, 0);
    n_checks++; if (yes !== want) begin n_fail++; $display("FAIL all_banks_yes got %h want %h", yes, want); end
    n_checks++; if (act_tr !== exp_act(on, 1, 1)) begin n_fail++; $display("FAIL all_banks_act got %h want %h", act_tr, exp_act(on, 1, 1)); end
  endtask

  initial begin
    test_reset();
    test_basic_train();
    test_bank_mask();
    test_back_to_back();
    test_abort();
    test_zero_pulses();
    test_async_reset();
    test_all_banks();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
